tiled_mm_controller: RTL and testbench
======================================

Name: tiled_mm_controller

Overview:
Next-generation sequencer for the N x N systolic matrix-multiply array. Adds a runtime inner dimension K, multi-tile sequencing, an accumulator-clear phase, a handshaked result-drain phase, abort and config-error reporting. It sits between the host/command interface and the PE array, input skew buffers and output collector.

Parameters:
N, 4, systolic array dimension (rows = cols = N), N >= 2
K_W, 16, width of cfg_k and of the phase counter
T_W, 8, width of cfg_tiles and tile_index

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low; 0 at a rising edge resets the block
start  input  1  request a job; sampled only in IDLE
abort  input  1  cancel the running job
cfg_k  input  K_W  inner dimension K; latched on accepted start
cfg_tiles  input  T_W  number of output tiles; latched on accepted start
drain_ready  input  1  output collector can take a row this cycle
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on normal job completion
aborted  output  1  one-cycle pulse when abort takes effect
cfg_error  output  1  one-cycle pulse when start is rejected
acc_clear  output  1  clear PE accumulators
load_enable  output  1  skew buffers feed the array
pe_enable  output  1  PEs multiply-accumulate
drain_valid  output  1  result row drain_row is presented
drain_row  output  $clog2(N)  row being drained
tile_index  output  T_W  tile being processed, 0-based
cycle_counter  output  K_W  cycles elapsed in the current phase

Behaviour:
- States: IDLE, CLEAR, LOADING, COMPUTING, DRAIN. Registered state; outputs decoded from state and counters.
- Reset (reset = 0 at an edge): state IDLE; busy, done, aborted, cfg_error, acc_clear, load_enable, pe_enable, drain_valid = 0; drain_row, tile_index, cycle_counter = 0; latched config = 0.
- IDLE: start = 1 with cfg_k != 0 and cfg_tiles != 0 latches K and T, sets tile_index = 0 and enters CLEAR. start with cfg_k == 0 or cfg_tiles == 0 pulses cfg_error the next cycle and stays in IDLE.
- CLEAR: exactly 1 cycle with acc_clear = 1, then LOADING.
- LOADING: K + N - 1 cycles, covering skewed K-deep operand streams. load_enable = 1 and pe_enable = 1. Compute K + N - 1 in K_W + 1 bits.
- COMPUTING: N cycles with pe_enable = 1 to flush the array, then DRAIN.
- DRAIN: drain_valid = 1 and drain_row starts at 0. A handshake (drain_valid & drain_ready) advances drain_row. With drain_ready low, drain_row holds. The handshake on row N-1 ends the tile:
  - if tile_index == T-1: go to IDLE and pulse done in the first IDLE cycle;
  - otherwise increment tile_index and go to CLEAR.
- cycle_counter: 0 on the first cycle of each phase, +1 per cycle, including DRAIN stall cycles. Saturates at all-ones and does not wrap.
- Timing for N=4, K=4, T=1, drain_ready held 1, start sampled at edge 0:
  - CLEAR: cycle 1
  - LOADING: cycles 2-8
  - COMPUTING: cycles 9-12
  - DRAIN: cycles 13-16
  - cycle 17: done = 1, busy = 0
- Each extra tile adds 16 cycles.
- start while busy: ignored, and the latched config does not change.
- abort = 1 in any non-IDLE state: next cycle is IDLE with aborted = 1. All enables and drain_valid go low that cycle. done is not pulsed and tile_index holds its last value. abort in IDLE has no effect.
- abort and the final drain handshake in the same cycle: abort wins (aborted pulses, done does not).
- start in the same cycle as a done pulse: accepted, because the block is in IDLE.
- reset = 0 mid-job: immediate return to reset values; no done or aborted pulse.

Optional Feature:
- Macro: MM_PERF_COUNTERS_EN.
- When defined, two extra outputs are present:
  - perf_busy_cycles (32 bits): counts cycles with busy = 1.
  - perf_stall_cycles (32 bits): counts cycles with drain_valid = 1 and drain_ready = 0.
- Both counters clear on an accepted start and on reset, saturate at all-ones, and hold while in IDLE.
- When not defined, these ports and their logic are absent.

Test Plan:
- N=4, cfg_k=4, cfg_tiles=1, drain_ready=1, start pulse -> acc_clear 1 cycle, load_enable 7 cycles, pe_enable 11 cycles, drain_row 0,1,2,3, done at cycle 17, busy low from cycle 17.
- N=4, cfg_k=2, cfg_tiles=3 -> tile_index steps 0,1,2; acc_clear pulses 3 times; a single done pulse 3 x 14 + 1 = 43 cycles after start.
- drain_ready low for 5 cycles while drain_row=1 -> drain_row holds at 1, drain_valid stays 1, done delayed by 5 cycles; with MM_PERF_COUNTERS_EN, perf_stall_cycles = 5.
- abort during LOADING at cycle 4 -> next cycle: IDLE, aborted=1, busy=0, all enables 0; no done pulse follows.
- start with cfg_k=0, and separately cfg_tiles=0 -> cfg_error pulse, busy stays 0; start again during a running job -> ignored, tile count unchanged.
- reset driven 0 during DRAIN -> all outputs at reset values on the next cycle; the next start runs a full, correct job.

Source files
------------

// File: rtl/tiled_mm_controller_if.sv
// Host/array-side bundle for tiled_mm_controller.
// The optional performance counter outputs appear only when MM_PERF_COUNTERS_EN is defined.
`default_nettype none

interface tiled_mm_controller_if #(
   parameter int N   = 4,
   parameter int K_W = 16,
   parameter int T_W = 8
);
   localparam int R_W = $clog2(N);

   logic           start;
   logic           abort;
   logic [K_W-1:0] cfg_k;
   logic [T_W-1:0] cfg_tiles;
   logic           drain_ready;
   logic           busy;
   logic           done;
   logic           aborted;
   logic           cfg_error;
   logic           acc_clear;
   logic           load_enable;
   logic           pe_enable;
   logic           drain_valid;
   logic [R_W-1:0] drain_row;
   logic [T_W-1:0] tile_index;
   logic [K_W-1:0] cycle_counter;
`ifdef MM_PERF_COUNTERS_EN
   logic [31:0]    perf_busy_cycles;
   logic [31:0]    perf_stall_cycles;
`endif

   modport master (
      output start, abort, cfg_k, cfg_tiles, drain_ready,
      input  busy, done, aborted, cfg_error, acc_clear, load_enable, pe_enable,
             drain_valid, drain_row, tile_index, cycle_counter
`ifdef MM_PERF_COUNTERS_EN
      , input perf_busy_cycles, perf_stall_cycles
`endif
   );

   modport slave (
      input  start, abort, cfg_k, cfg_tiles, drain_ready,
      output busy, done, aborted, cfg_error, acc_clear, load_enable, pe_enable,
             drain_valid, drain_row, tile_index, cycle_counter
`ifdef MM_PERF_COUNTERS_EN
      , output perf_busy_cycles, perf_stall_cycles
`endif
   );
endinterface

`default_nettype wire

// File: rtl/tiled_mm_controller.sv
//------------------------------------------------------------------------------
// Module      : tiled_mm_controller
// Description : Multi-tile sequencer for an N x N systolic matrix-multiply array
//               (clear / load / compute / handshaked drain, abort, config error).
//               Optional macro MM_PERF_COUNTERS_EN adds busy/stall cycle counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tiled_mm_controller #(
   parameter int N   = 4,
   parameter int K_W = 16,
   parameter int T_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   tiled_mm_controller_if.slave bus
);
   localparam int R_W = $clog2(N);
   localparam logic [K_W:0]   COMP_LAST  = (K_W+1)'(N - 1);
   localparam logic [K_W:0]   LOAD_EXTRA = (K_W+1)'(N - 1);
   localparam logic [R_W-1:0] ROW_LAST   = R_W'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CLEAR     = 3'd1,
      S_LOADING   = 3'd2,
      S_COMPUTING = 3'd3,
      S_DRAIN     = 3'd4
   } state_t;

   state_t         state;
   state_t         state_nx;
   // One bit wider than cycle_counter so long LOADING phases still terminate
   logic [K_W:0]   phase_cnt;
   logic [K_W-1:0] k_lat;
   logic [T_W-1:0] tiles_lat;
   logic [T_W-1:0] tile_idx;
   logic [R_W-1:0] row;
   logic           done_q;
   logic           aborted_q;
   logic           cfg_error_q;

   logic           cfg_ok;
   logic           start_ok;
   logic           handshake;
   logic           last_row;
   logic           last_tile;
   logic           abort_now;
   logic [K_W:0]   load_len;
   logic [K_W:0]   load_last;

   assign cfg_ok    = (bus.cfg_k != '0) && (bus.cfg_tiles != '0);
   assign start_ok  = (state == S_IDLE) && bus.start && cfg_ok;
   assign handshake = (state == S_DRAIN) && bus.drain_ready;
   assign last_row  = (row == ROW_LAST);
   assign last_tile = (tile_idx == tiles_lat - T_W'(1));
   assign abort_now = (state != S_IDLE) && bus.abort;
   assign load_len  = {1'b0, k_lat} + LOAD_EXTRA;
   assign load_last = load_len - (K_W+1)'(1);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:      if (start_ok) state_nx = S_CLEAR;
         S_CLEAR:     state_nx = S_LOADING;
         S_LOADING:   if (phase_cnt == load_last) state_nx = S_COMPUTING;
         S_COMPUTING: if (phase_cnt == COMP_LAST) state_nx = S_DRAIN;
         S_DRAIN:     if (handshake && last_row) state_nx = last_tile ? S_IDLE : S_CLEAR;
         default:     state_nx = S_IDLE;
      endcase
      if (abort_now) state_nx = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         phase_cnt   <= '0;
         k_lat       <= '0;
         tiles_lat   <= '0;
         tile_idx    <= '0;
         row         <= '0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
         cfg_error_q <= 1'b0;
      end else begin
         state       <= state_nx;
         done_q      <= handshake && last_row && last_tile && !bus.abort;
         aborted_q   <= abort_now;
         cfg_error_q <= (state == S_IDLE) && bus.start && !cfg_ok;

         // Every phase change is a state change, so this restarts the counter per phase
         if (state_nx != state || state_nx == S_IDLE)
            phase_cnt <= '0;
         else if (phase_cnt != '1)
            phase_cnt <= phase_cnt + (K_W+1)'(1);

         if (state_nx != S_DRAIN)
            row <= '0;
         else if (handshake)
            row <= row + R_W'(1);

         if (start_ok) begin
            k_lat     <= bus.cfg_k;
            tiles_lat <= bus.cfg_tiles;
            tile_idx  <= '0;
         end else if (state_nx == S_CLEAR && state == S_DRAIN) begin
            tile_idx  <= tile_idx + T_W'(1);
         end
      end
   end

   assign bus.busy          = (state != S_IDLE);
   assign bus.done          = done_q;
   assign bus.aborted       = aborted_q;
   assign bus.cfg_error     = cfg_error_q;
   assign bus.acc_clear     = (state == S_CLEAR);
   assign bus.load_enable   = (state == S_LOADING);
   assign bus.pe_enable     = (state == S_LOADING) || (state == S_COMPUTING);
   assign bus.drain_valid   = (state == S_DRAIN);
   assign bus.drain_row     = row;
   assign bus.tile_index    = tile_idx;
   assign bus.cycle_counter = phase_cnt[K_W] ? {K_W{1'b1}} : phase_cnt[K_W-1:0];

`ifdef MM_PERF_COUNTERS_EN
   logic [31:0] perf_busy;
   logic [31:0] perf_stall;

   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_busy  <= '0;
         perf_stall <= '0;
      end else if (state == S_IDLE) begin
         if (start_ok) begin
            perf_busy  <= '0;
            perf_stall <= '0;
         end
      end else begin
         if (perf_busy != '1)
            perf_busy <= perf_busy + 32'd1;
         if (state == S_DRAIN && !bus.drain_ready && perf_stall != '1)
            perf_stall <= perf_stall + 32'd1;
      end
   end

   assign bus.perf_busy_cycles  = perf_busy;
   assign bus.perf_stall_cycles = perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tiled_mm_controller.sv
// Directed, table-driven bench for tiled_mm_controller with N=4, K_W=16, T_W=8.
`default_nettype none

module tb_tiled_mm_controller;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   tiled_mm_controller_if #(.N(4), .K_W(16), .T_W(8)) bus ();

   tiled_mm_controller #(.N(4), .K_W(16), .T_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic busy, clr, ld, pe, dv, dn;
      int   row;
      int   cc;
   } trace_t;

   typedef struct {
      int k;
      int t;
      bit err;
      int exp_cyc;
      int exp_clears;
   } job_t;

   trace_t trace [17];
   job_t   jobs  [6];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulses start for one edge; on return the bench sits in cycle 1 of the job.
   task automatic launch(input int k, input int t);
      bus.cfg_k     = 16'(k);
      bus.cfg_tiles = 8'(t);
      bus.start     = 1'b1;
      step();
      bus.start     = 1'b0;
   endtask

   task automatic wait_done(input int first, output int cyc, output int clears);
      cyc    = first;
      clears = 0;
      while (bus.done !== 1'b1 && cyc < 400) begin
         clears += int'(bus.acc_clear);
         step();
         cyc++;
      end
   endtask

   int cyc, clears, dn_cnt;

   initial begin
      checks = 0;
      errors = 0;
      // Expected per-cycle outputs: busy clr ld pe dv dn row cc
      trace[0]  = '{1,1,0,0,0,0,0,0};
      trace[1]  = '{1,0,1,1,0,0,0,0};
      trace[2]  = '{1,0,1,1,0,0,0,1};
      trace[3]  = '{1,0,1,1,0,0,0,2};
      trace[4]  = '{1,0,1,1,0,0,0,3};
      trace[5]  = '{1,0,1,1,0,0,0,4};
      trace[6]  = '{1,0,1,1,0,0,0,5};
      trace[7]  = '{1,0,1,1,0,0,0,6};
      trace[8]  = '{1,0,0,1,0,0,0,0};
      trace[9]  = '{1,0,0,1,0,0,0,1};
      trace[10] = '{1,0,0,1,0,0,0,2};
      trace[11] = '{1,0,0,1,0,0,0,3};
      trace[12] = '{1,0,0,0,1,0,0,0};
      trace[13] = '{1,0,0,0,1,0,1,1};
      trace[14] = '{1,0,0,0,1,0,2,2};
      trace[15] = '{1,0,0,0,1,0,3,3};
      trace[16] = '{0,0,0,0,0,1,0,0};
      // k, tiles, cfg error, done cycle, clear pulses
      jobs[0] = '{4, 1, 0, 17, 1};
      jobs[1] = '{2, 3, 0, 43, 3};
      jobs[2] = '{1, 2, 0, 27, 2};
      jobs[3] = '{0, 1, 1, 0, 0};
      jobs[4] = '{3, 0, 1, 0, 0};
      jobs[5] = '{10, 1, 0, 23, 1};

      bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_k = '0; bus.cfg_tiles = '0;
      bus.drain_ready = 1'b1;
      reset = 1'b0;
      repeat (3) step();
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_enables", {bus.acc_clear, bus.load_enable, bus.pe_enable, bus.drain_valid}, 0);
      chk("reset_counters", {bus.drain_row, bus.tile_index, bus.cycle_counter}, 0);
      reset = 1'b1;
      step();

      // Abort while idle must do nothing
      bus.abort = 1'b1;
      step();
      chk("idle_abort", bus.aborted, 0);
      bus.abort = 1'b0;

      // Cycle-accurate trace of a single K=4 tile
      launch(4, 1);
      for (int i = 0; i < 17; i++) begin
         chk($sformatf("tr%0d_busy", i + 1), bus.busy, trace[i].busy);
         chk($sformatf("tr%0d_clr", i + 1), bus.acc_clear, trace[i].clr);
         chk($sformatf("tr%0d_ld", i + 1), bus.load_enable, trace[i].ld);
         chk($sformatf("tr%0d_pe", i + 1), bus.pe_enable, trace[i].pe);
         chk($sformatf("tr%0d_dv", i + 1), bus.drain_valid, trace[i].dv);
         chk($sformatf("tr%0d_done", i + 1), bus.done, trace[i].dn);
         chk($sformatf("tr%0d_row", i + 1), bus.drain_row, trace[i].row);
         chk($sformatf("tr%0d_cc", i + 1), bus.cycle_counter, trace[i].cc);
         step();
      end
      chk("tr_done_pulse_len", bus.done, 0);

      // Job table: latency, clear count, final tile index, config errors
      for (int j = 0; j < 6; j++) begin
         launch(jobs[j].k, jobs[j].t);
         if (jobs[j].err) begin
            chk($sformatf("job%0d_cfg_error", j), bus.cfg_error, 1);
            chk($sformatf("job%0d_busy", j), bus.busy, 0);
            step();
            chk($sformatf("job%0d_cfg_error_len", j), bus.cfg_error, 0);
            chk($sformatf("job%0d_still_idle", j), bus.busy, 0);
         end else begin
            wait_done(1, cyc, clears);
            chk($sformatf("job%0d_done_cycle", j), cyc, jobs[j].exp_cyc);
            chk($sformatf("job%0d_clears", j), clears, jobs[j].exp_clears);
            chk($sformatf("job%0d_last_tile", j), bus.tile_index, jobs[j].t - 1);
            step();
            chk($sformatf("job%0d_done_len", j), bus.done, 0);
         end
      end

      // Drain stall: drain_ready low for 5 cycles while row 1 is presented
      launch(4, 1);
      repeat (13) step();
      chk("stall_row_before", bus.drain_row, 1);
      bus.drain_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("stall%0d_row", i), bus.drain_row, 1);
         chk($sformatf("stall%0d_dv", i), bus.drain_valid, 1);
      end
      chk("stall_cc", bus.cycle_counter, 6);
      bus.drain_ready = 1'b1;
      wait_done(19, cyc, clears);
      chk("stall_done_cycle", cyc, 22);
`ifdef MM_PERF_COUNTERS_EN
      chk("perf_stall", bus.perf_stall_cycles, 5);
      chk("perf_busy", bus.perf_busy_cycles, 21);
      step();
      chk("perf_hold_idle", bus.perf_busy_cycles, 21);
`else
      step();
`endif

      // Abort during LOADING at cycle 4
      launch(4, 1);
      repeat (3) step();
      chk("abort_pre_loading", bus.load_enable, 1);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      chk("abort_pulse", bus.aborted, 1);
      chk("abort_busy", bus.busy, 0);
      chk("abort_enables", {bus.acc_clear, bus.load_enable, bus.pe_enable, bus.drain_valid}, 0);
      chk("abort_tile", bus.tile_index, 0);
      dn_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         dn_cnt += int'(bus.done) + int'(bus.aborted);
      end
      chk("abort_no_done", dn_cnt, 0);

      // Abort coinciding with the final drain handshake: abort wins
      launch(4, 1);
      repeat (15) step();
      chk("abort_last_row", bus.drain_row, 3);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      chk("abort_last_aborted", bus.aborted, 1);
      chk("abort_last_done", bus.done, 0);
      step();

      // Start while busy is ignored; start on the done cycle is accepted
      launch(2, 3);
      repeat (4) step();
      bus.cfg_k = 16'd4; bus.cfg_tiles = 8'd1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("busy_start_no_err", bus.cfg_error, 0);
      wait_done(6, cyc, clears);
      chk("busy_start_done_cycle", cyc, 43);
      chk("busy_start_tiles", bus.tile_index, 2);
      launch(4, 1);
      chk("done_start_clr", bus.acc_clear, 1);
      chk("done_start_busy", bus.busy, 1);
      wait_done(1, cyc, clears);
      chk("done_start_cycle", cyc, 17);
      step();

      // Reset in the second tile's DRAIN, then a clean job
      launch(4, 2);
      repeat (29) step();
      chk("rst_pre_tile", bus.tile_index, 1);
      chk("rst_pre_dv", bus.drain_valid, 1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_outputs", {bus.done, bus.aborted, bus.drain_valid, bus.pe_enable}, 0);
      chk("rst_counters", {bus.drain_row, bus.tile_index, bus.cycle_counter}, 0);
      step();
      chk("rst_no_pulse", {bus.done, bus.aborted}, 0);
      launch(4, 1);
      wait_done(1, cyc, clears);
      chk("rst_rerun_cycle", cyc, 17);
      chk("rst_rerun_clears", clears, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
